// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment type and low-active patterns for hex digits 0-F
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // Bit order g..a, a segment lights when its bit is 0
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b0000011;
  localparam seg_t SEG_C = 7'b1000110;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - value/load inputs and segment/digit pins of the scan driver
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 6
);
  import seg7_pkg::*;

  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic [NUM_DIGITS-1:0]   blink_mask;
  seg_t                    seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   digit_en;

  modport master (
    output value, load, dp_in, blank_lz, blink_mask,
    input  seg_out, dp_out, digit_en
  );

  modport slave (
    input  value, load, dp_in, blank_lz, blink_mask,
    output seg_out, dp_out, digit_en
  );

endinterface

// File: rtl/seg7_nibble_decode.sv
// rtl/seg7_nibble_decode.sv - combinational hex nibble to low-active segment decoder
module seg7_nibble_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg_t       o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nib)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment scanner with leading-zero blanking
// Optional digit blinking is built when SEG7_BLINK_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   bus
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic                    r_blank;
  logic [DIV_W-1:0]        r_div;
  logic [IDX_W-1:0]        r_idx;
  seg_t                    r_seg;
  logic                    r_dp_out;
  logic [NUM_DIGITS-1:0]   r_digit_en;

  logic                    w_tc;
  logic [3:0]              w_nib;
  logic                    w_dp_bit;
  logic                    w_lz_blank;
  logic                    w_run_zero;
  logic [NUM_DIGITS-1:0]   w_en_next;
  logic                    w_blink_off;
  seg_t                    w_seg_dec;

  assign w_tc = (r_div == DIV_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
      r_dp    <= '0;
      r_blank <= 1'b0;
    end else if (bus.load) begin
      r_value <= bus.value;
      r_dp    <= bus.dp_in;
      r_blank <= bus.blank_lz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (w_tc) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Scanning from the top digit down, w_run_zero holds "this and all higher nibbles are zero"
  always_comb begin
    w_nib      = 4'h0;
    w_dp_bit   = 1'b0;
    w_en_next  = '1;
    w_lz_blank = 1'b0;
    w_run_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_run_zero = w_run_zero & (r_value[k*4 +: 4] == 4'h0);
      if (r_idx == IDX_W'(k)) begin
        w_nib        = r_value[k*4 +: 4];
        w_dp_bit     = r_dp[k];
        w_en_next[k] = 1'b0;
        w_lz_blank   = r_blank & w_run_zero & (k != 0);
      end
    end
  end

  seg7_nibble_decode u_decode (
    .i_nib (w_nib),
    .o_seg (w_seg_dec)
  );

`ifdef SEG7_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  logic               w_mask_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // blink_mask is sampled live so software can start/stop blinking without a reload
  always_comb begin
    w_mask_bit = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) w_mask_bit = bus.blink_mask[k];
    end
  end

  assign w_blink_off = r_blink_phase & w_mask_bit;
`else
  logic w_unused;
  assign w_unused    = ^{bus.blink_mask, BLINK_DIV[0]};
  assign w_blink_off = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg      <= SEG_BLANK;
      r_dp_out   <= 1'b1;
      r_digit_en <= '1;
    end else begin
      r_seg      <= (w_lz_blank || w_blink_off) ? SEG_BLANK : w_seg_dec;
      r_dp_out   <= w_blink_off ? 1'b1 : ~w_dp_bit;
      r_digit_en <= w_tc ? '1 : w_en_next;
    end
  end

  assign bus.seg_out  = r_seg;
  assign bus.dp_out   = r_dp_out;
  assign bus.digit_en = r_digit_en;

endmodule
